// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences MW-stage loads/stores over a req/gnt/rvalid bus.
// Define DMEM_TIMEOUT_EN to enable the REQ/WAIT abort timer and bus_err pulse.
module dmem_access_ctrl #(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mem_rdMW,
   input  logic            mem_wrMW,
   input  logic [AW-1:0]   addrMW,
   input  logic [DW-1:0]   wdataMW,
   input  logic [DW/8-1:0] maskMW,
   output logic            dbus_req,
   output logic            dbus_we,
   output logic [AW-1:0]   dbus_addr,
   output logic [DW-1:0]   dbus_wdata,
   output logic [DW/8-1:0] dbus_mask,
   input  logic            dbus_gnt,
   input  logic            dbus_rvalid,
   input  logic [DW-1:0]   dbus_rdata,
   output logic [DW-1:0]   load_data,
   output logic            stall,
   output logic            stallMW,
   output logic            bus_err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [DW/8-1:0]   mask_q, mask_d;
   logic [DW-1:0]     ld_q, ld_d;
   logic              err_q, err_d;
   logic              acc;
   logic              timeout;

   assign acc = mem_rdMW | mem_wrMW;

`ifdef DMEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Abort timer: zero while idle, counts each REQ/WAIT cycle
   always_comb begin
      cnt_d   = cnt_q;
      timeout = 1'b0;
      if (state_q == IDLE) begin
         cnt_d = '0;
      end else if (state_q == REQ || state_q == WAIT) begin
         cnt_d   = cnt_q + 1'b1;
         timeout = (cnt_d == CW'(TIMEOUT_CYCLES));
      end
   end

   // Abort timer register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   // Next-state, bus latch and load capture logic
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      mask_d  = mask_q;
      ld_d    = ld_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (acc) begin
               // a simultaneous rd+wr is treated as a store
               we_d    = mem_wrMW;
               addr_d  = addrMW;
               wdata_d = wdataMW;
               mask_d  = maskMW;
               state_d = REQ;
            end
         end
         REQ: begin
            if (dbus_gnt) begin
               if (we_q) begin
                  state_d = DONE;
               end else if (dbus_rvalid) begin
                  ld_d    = dbus_rdata;
                  state_d = DONE;
               end else begin
                  state_d = WAIT;
               end
            end else if (timeout) begin
               ld_d    = '0;
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         WAIT: begin
            if (dbus_rvalid) begin
               ld_d    = dbus_rdata;
               state_d = DONE;
            end else if (timeout) begin
               ld_d    = '0;
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         mask_q  <= '0;
         ld_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         mask_q  <= mask_d;
         ld_q    <= ld_d;
         err_q   <= err_d;
      end
   end

   assign dbus_req   = (state_q == REQ);
   assign dbus_we    = we_q;
   assign dbus_addr  = addr_q;
   assign dbus_wdata = wdata_q;
   assign dbus_mask  = mask_q;
   assign load_data  = ld_q;
   assign bus_err    = err_q;

   // stall is combinational so the pipeline freezes the cycle an access appears
   assign stall   = rst_n & acc & (state_q != DONE);
   assign stallMW = stall;

endmodule
